instruction_decode: RTL

//   ID stage of the 5-stage pipeline; consumes the IF/ID outputs (instruccion, pc+1).

---
 rtl/id_pkg.sv | 68 ++++++
 rtl/register_file.sv | 39 +++
 rtl/instruction_decode.sv | 116 +++++++++++
 3 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU op classes, control bundle.
// Helper functions keep the opcode-to-control table in one place.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.alu_op     = ALU_OP_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_OP_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

  // Only these formats actually consume rt as a source operand.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/register_file.sv
// 2-read/1-write register file, r0 hardwired to zero, async active-low clear.
// ID_RF_BYPASS_EN makes a same-cycle write visible on the read ports (write-through).
module register_file #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0]     rdata1_o,
  output logic [DATA_W-1:0]     rdata2_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i
);

  localparam int NREGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
`ifdef ID_RF_BYPASS_EN
    if (we_i && (waddr_i != '0) && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (we_i && (waddr_i != '0) && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`endif
  end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: register file read, control decode, sign extension, load-use stall, ID/EX register.
// Build option ID_RF_BYPASS_EN enables register-file write-through on same-cycle read.
module instruction_decode
  import id_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 11,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     instruccion,
  input  logic [PC_W-1:0]       pc,
  input  logic                  flush,
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] rt_ex,
  input  logic                  reg_write_wb,
  input  logic [REG_ADDR_W-1:0] write_reg_wb,
  input  logic [DATA_W-1:0]     write_data_wb,
  output logic                  stall,
  output logic [PC_W-1:0]       pc_ex,
  output logic [DATA_W-1:0]     read_data_1,
  output logic [DATA_W-1:0]     read_data_2,
  output logic [DATA_W-1:0]     imm_ext,
  output logic [REG_ADDR_W-1:0] rs_ex,
  output logic [REG_ADDR_W-1:0] rt_ex_o,
  output logic [REG_ADDR_W-1:0] rd_ex,
  output logic                  reg_dst,
  output logic                  alu_src,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  branch,
  output logic [1:0]            alu_op
);

  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0]     rf_rdata1, rf_rdata2;
  logic [DATA_W-1:0]     imm_d;
  logic                  hazard;
  ctrl_t                 ctrl_d, ctrl_q;

  logic [PC_W-1:0]       pc_q;
  logic [DATA_W-1:0]     rd1_q, rd2_q, imm_q;
  logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;

  assign opcode = instruccion[31:26];
  assign rs     = instruccion[25:21];
  assign rt     = instruccion[20:16];
  assign rd     = instruccion[15:11];
  assign imm_d  = {{(DATA_W-16){instruccion[15]}}, instruccion[15:0]};

  register_file #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rf (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2),
    .we_i     (reg_write_wb),
    .waddr_i  (write_reg_wb),
    .wdata_i  (write_data_wb)
  );

  assign hazard = mem_read_ex && (rt_ex != '0) &&
                  ((rt_ex == rs) || ((rt_ex == rt) && op_uses_rt(opcode)));

  // A taken branch squashes the wrong-path instruction, so there is nothing to stall for.
  assign stall  = hazard && !flush && reset_n;

  assign ctrl_d = (hazard || flush) ? CTRL_NOP : decode_ctrl(opcode);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= CTRL_NOP;
    end else begin
      pc_q   <= pc;
      rd1_q  <= rf_rdata1;
      rd2_q  <= rf_rdata2;
      imm_q  <= imm_d;
      rs_q   <= rs;
      rt_q   <= rt;
      rd_q   <= rd;
      ctrl_q <= ctrl_d;
    end
  end

  assign pc_ex       = pc_q;
  assign read_data_1 = rd1_q;
  assign read_data_2 = rd2_q;
  assign imm_ext     = imm_q;
  assign rs_ex       = rs_q;
  assign rt_ex_o     = rt_q;
  assign rd_ex       = rd_q;
  assign reg_dst     = ctrl_q.reg_dst;
  assign alu_src     = ctrl_q.alu_src;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_write   = ctrl_q.reg_write;
  assign branch      = ctrl_q.branch;
  assign alu_op      = ctrl_q.alu_op;

endmodule
